alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_pkg.sv | 14 +
 rtl/alu_mc_if.sv | 16 +
 rtl/alu_mc_muldiv_iter.sv | 83 ++++++++
 rtl/alu_mc.sv | 113 +++++++++++
 tb/tb_alu_mc.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared op encodings, FSM state type and default width for alu_mc.
// Contents: WIDTH_DEF, OP_* 6-bit opcodes, state_t with S_IDLE/S_MUL/S_DIV/S_DONE.
package alu_pkg;
    localparam int WIDTH_DEF = 32;
    localparam logic [5:0] OP_OR = 6'b000100, OP_NOR = 6'b000101, OP_XOR = 6'b000110,
        OP_SLL = 6'b001000, OP_SRL = 6'b001001, OP_LUI = 6'b001010, OP_AND = 6'b010001,
        OP_SRA = 6'b011001, OP_ADD = 6'b100000, OP_ADDU = 6'b100001, OP_SUB = 6'b100010,
        OP_SUBU = 6'b100011, OP_SLLV = 6'b101000, OP_SRLV = 6'b101001, OP_SLT = 6'b101010,
        OP_SLTU = 6'b101011, OP_MULT = 6'b110000, OP_MULTU = 6'b110001, OP_DIV = 6'b110010,
        OP_DIVU = 6'b110011, OP_MTHI = 6'b110100, OP_MTLO = 6'b110101, OP_MFHI = 6'b110110,
        OP_MFLO = 6'b110111, OP_SRAV = 6'b111001;
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3;
endpackage

// File: rtl/alu_mc_if.sv
// alu_mc_if: request/result bundle of alu_mc.
// Ports: i_start, i_op, i_a, i_b, i_sa (requester -> ALU); o_y, o_hi, o_lo, o_busy,
// o_done, o_overflow (ALU -> requester). master = requester side, slave = ALU side.
interface alu_mc_if import alu_pkg::*; #(parameter int WIDTH = WIDTH_DEF) ();
    localparam int SHW = $clog2(WIDTH);
    logic             i_start;
    logic [5:0]       i_op;
    logic [WIDTH-1:0] i_a, i_b;
    logic [SHW-1:0]   i_sa;
    logic [WIDTH-1:0] o_y, o_hi, o_lo;
    logic             o_busy, o_done, o_overflow;
    modport master (output i_start, i_op, i_a, i_b, i_sa,
                    input o_y, o_hi, o_lo, o_busy, o_done, o_overflow);
    modport slave (input i_start, i_op, i_a, i_b, i_sa,
                   output o_y, o_hi, o_lo, o_busy, o_done, o_overflow);
endinterface

// File: rtl/alu_mc_muldiv_iter.sv
// muldiv_iter: radix-2 shift-add multiplier / restoring divider on operand magnitudes.
// Ports: clk, rst (async high), i_load (latch operands, restart count), i_signed,
// i_div (only with ALU_MC_DIV_EN), i_a, i_b; o_last (final iteration this cycle),
// o_hi/o_lo (signed-corrected result available at the final iteration edge).
// Macro ALU_MC_DIV_EN: when undefined the divider datapath is not built.
module muldiv_iter import alu_pkg::*; #(parameter int WIDTH = WIDTH_DEF) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_signed,
`ifdef ALU_MC_DIV_EN
    input  logic             i_div,
`endif
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_last,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    localparam int SHW = $clog2(WIDTH);
    logic [SHW-1:0]     r_cnt;
    logic [WIDTH-1:0]   r_hi, r_lo, r_d, w_hi_n, w_lo_n, w_am, w_bm;
    logic               r_negq;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_prod, w_pres;
    assign w_am = (i_signed && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_bm = (i_signed && i_b[WIDTH-1]) ? -i_b : i_b;
    assign o_last = r_cnt == SHW'(WIDTH-1);
    // multiplier lives in r_lo and shifts out while the product shifts in from r_hi
    assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_d} : '0);
    assign w_prod = {w_sum, r_lo[WIDTH-1:1]};
    assign w_pres = r_negq ? -w_prod : w_prod;
`ifdef ALU_MC_DIV_EN
    logic               r_div, r_negr, r_dz;
    logic [WIDTH-1:0]   r_a, w_rem, w_quo;
    logic [WIDTH:0]     w_t;
    // partial remainder is always < divisor, so W+1 bits hold the trial subtraction
    assign w_t = {r_hi, r_lo[WIDTH-1]} - {1'b0, r_d};
    assign w_rem = w_t[WIDTH] ? {r_hi[WIDTH-2:0], r_lo[WIDTH-1]} : w_t[WIDTH-1:0];
    assign w_quo = {r_lo[WIDTH-2:0], ~w_t[WIDTH]};
    assign w_hi_n = r_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
    assign w_lo_n = r_div ? w_quo : w_prod[WIDTH-1:0];
    assign o_hi = !r_div ? w_pres[2*WIDTH-1:WIDTH] : r_dz ? r_a : r_negr ? -w_rem : w_rem;
    assign o_lo = !r_div ? w_pres[WIDTH-1:0] : r_dz ? '1 : r_negq ? -w_quo : w_quo;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= 1'b0;
            r_negr <= 1'b0;
            r_dz <= 1'b0;
            r_a <= '0;
        end else if (i_load) begin
            r_div <= i_div;
            r_negr <= i_signed && i_a[WIDTH-1];
            r_dz <= i_b == '0;
            r_a <= i_a;
        end
    end
`else
    assign w_hi_n = w_prod[2*WIDTH-1:WIDTH];
    assign w_lo_n = w_prod[WIDTH-1:0];
    assign o_hi = w_pres[2*WIDTH-1:WIDTH];
    assign o_lo = w_pres[WIDTH-1:0];
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_hi <= '0;
            r_lo <= '0;
            r_d <= '0;
            r_negq <= 1'b0;
        end else if (i_load) begin
            r_cnt <= '0;
            r_hi <= '0;
            r_lo <= w_am;
            r_d <= w_bm;
            r_negq <= i_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
        end else begin
            r_cnt <= r_cnt + 1'b1;
            r_hi <= w_hi_n;
            r_lo <= w_lo_n;
        end
    end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle MIPS-style ALU with HI/LO registers and iterative mult/div.
// Ports: clk, rst (async high), bus (alu_mc_if.slave: i_start/i_op/i_a/i_b/i_sa in,
// o_y/o_hi/o_lo/o_busy/o_done/o_overflow out).
// Macro ALU_MC_DIV_EN: enables div/divu; otherwise they behave as unknown ops.
module alu_mc import alu_pkg::*; #(parameter int WIDTH = WIDTH_DEF) (
    input logic   clk,
    input logic   rst,
    alu_mc_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    state_t           r_state;
    logic [WIDTH-1:0] r_y, r_hi, r_lo, w_y, w_mhi, w_mlo, w_sum, w_dif, w_a, w_b;
    logic             r_done, r_ov, w_ov, w_busy, w_acc, w_mul, w_div, w_last;
    logic [5:0]       w_op;
    assign w_op = bus.i_op;
    assign w_a = bus.i_a;
    assign w_b = bus.i_b;
    assign w_busy = r_state == S_MUL || r_state == S_DIV;
    assign w_acc = bus.i_start && !w_busy;
    assign w_mul = w_op == OP_MULT || w_op == OP_MULTU;
`ifdef ALU_MC_DIV_EN
    assign w_div = w_op == OP_DIV || w_op == OP_DIVU;
`else
    assign w_div = 1'b0;
`endif
    assign w_sum = w_a + w_b;
    assign w_dif = w_a - w_b;
    always_comb begin
        w_y = '0;
        w_ov = 1'b0;
        case (w_op)
            OP_XOR:  w_y = w_a ^ w_b;
            OP_NOR:  w_y = ~(w_a | w_b);
            OP_AND:  w_y = w_a & w_b;
            OP_OR:   w_y = w_a | w_b;
            OP_LUI:  w_y = WIDTH'({w_b[15:0], 16'h0000});
            OP_SLL:  w_y = w_b << bus.i_sa;
            OP_SRL:  w_y = w_b >> bus.i_sa;
            OP_SRA:  w_y = WIDTH'($signed(w_b) >>> bus.i_sa);
            OP_SLLV: w_y = w_b << w_a[SHW-1:0];
            OP_SRLV: w_y = w_b >> w_a[SHW-1:0];
            OP_SRAV: w_y = WIDTH'($signed(w_b) >>> w_a[SHW-1:0]);
            OP_ADD: begin
                w_y = w_sum;
                w_ov = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
            end
            OP_ADDU: w_y = w_sum;
            OP_SUB: begin
                w_y = w_dif;
                w_ov = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_dif[WIDTH-1] != w_a[WIDTH-1]);
            end
            OP_SUBU: w_y = w_dif;
            OP_SLT:  w_y = WIDTH'($signed(w_a) < $signed(w_b));
            OP_SLTU: w_y = WIDTH'(w_a < w_b);
            OP_MTHI, OP_MTLO: w_y = w_a;
            OP_MFHI: w_y = r_hi;
            OP_MFLO: w_y = r_lo;
            default: w_y = '0;
        endcase
    end
    // signed variants (mult, div) have op[0]=0, unsigned ones op[0]=1
    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk(clk),
        .rst(rst),
        .i_load(w_acc && (w_mul || w_div)),
        .i_signed(!w_op[0]),
`ifdef ALU_MC_DIV_EN
        .i_div(w_div),
`endif
        .i_a(w_a),
        .i_b(w_b),
        .o_last(w_last),
        .o_hi(w_mhi),
        .o_lo(w_mlo)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_y <= '0;
            r_hi <= '0;
            r_lo <= '0;
            r_done <= 1'b0;
            r_ov <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_acc && (w_mul || w_div)) begin
                r_state <= w_mul ? S_MUL : S_DIV;
                r_ov <= 1'b0;
            end else if (w_acc) begin
                r_state <= S_IDLE;
                r_y <= w_y;
                r_ov <= w_ov;
                r_done <= 1'b1;
                r_hi <= w_op == OP_MTHI ? w_a : r_hi;
                r_lo <= w_op == OP_MTLO ? w_a : r_lo;
            end else if (w_busy && w_last) begin
                r_state <= S_DONE;
                r_y <= w_mlo;
                r_hi <= w_mhi;
                r_lo <= w_mlo;
                r_done <= 1'b1;
            end else if (r_state == S_DONE) begin
                r_state <= S_IDLE;
            end
        end
    end
    assign bus.o_y = r_y;
    assign bus.o_hi = r_hi;
    assign bus.o_lo = r_lo;
    assign bus.o_busy = w_busy;
    assign bus.o_done = r_done;
    assign bus.o_overflow = r_ov;
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: randomized self-checking bench for alu_mc against an arithmetic reference model.
module tb_alu_mc;
    import alu_pkg::*;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    alu_mc_if #(.WIDTH(32)) bus ();
    alu_mc #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
    int n_tests = 0;
    int n_fail = 0;
    logic [31:0] m_hi, m_lo;

    function automatic void model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] s, output logic [31:0] y, output logic ov,
                                  output int lat);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint r;
        logic [63:0] p;
        y = '0;
        ov = 1'b0;
        lat = 1;
        case (op)
            OP_XOR:  y = a ^ b;
            OP_NOR:  y = ~(a | b);
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_LUI:  y = {b[15:0], 16'h0000};
            OP_SLL:  y = b << s;
            OP_SRL:  y = b >> s;
            OP_SRA:  y = 32'(sb >>> s);
            OP_SLLV: y = b << a[4:0];
            OP_SRLV: y = b >> a[4:0];
            OP_SRAV: y = 32'(sb >>> a[4:0]);
            OP_ADD: begin
                r = sa + sb;
                y = 32'(r);
                ov = r != longint'($signed(32'(r)));
            end
            OP_ADDU: y = a + b;
            OP_SUB: begin
                r = sa - sb;
                y = 32'(r);
                ov = r != longint'($signed(32'(r)));
            end
            OP_SUBU: y = a - b;
            OP_SLT:  y = {31'b0, sa < sb};
            OP_SLTU: y = {31'b0, a < b};
            OP_MTHI: begin m_hi = a; y = a; end
            OP_MTLO: begin m_lo = a; y = a; end
            OP_MFHI: y = m_hi;
            OP_MFLO: y = m_lo;
            OP_MULT: begin
                p = 64'(sa * sb);
                {m_hi, m_lo} = p;
                y = m_lo;
                lat = 33;
            end
            OP_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                {m_hi, m_lo} = p;
                y = m_lo;
                lat = 33;
            end
`ifdef ALU_MC_DIV_EN
            OP_DIV: begin
                if (b == 0) begin m_lo = '1; m_hi = a; end
                else begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
                y = m_lo;
                lat = 33;
            end
            OP_DIVU: begin
                if (b == 0) begin m_lo = '1; m_hi = a; end
                else begin m_lo = 32'({32'b0, a} / {32'b0, b}); m_hi = 32'({32'b0, a} % {32'b0, b}); end
                y = m_lo;
                lat = 33;
            end
`endif
            default: y = '0;
        endcase
    endfunction

    // issue one request; operands are scrambled after acceptance to prove they were latched
    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] s, output int lat, output int nb);
        @(negedge clk);
        bus.i_op = op;
        bus.i_a = a;
        bus.i_b = b;
        bus.i_sa = s;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        lat = 1;
        nb = 0;
        while (!bus.o_done && lat < 100) begin
            if (bus.o_busy) nb++;
            bus.i_a = $urandom;
            bus.i_b = $urandom;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({bus.o_y, bus.o_hi, bus.o_lo, bus.o_busy, bus.o_done, bus.o_overflow} !== '0) begin
            $display("FAIL reset: y=%h hi=%h lo=%h busy=%b done=%b ov=%b, want all 0",
                     bus.o_y, bus.o_hi, bus.o_lo, bus.o_busy, bus.o_done, bus.o_overflow);
            n_fail++;
        end
        @(negedge clk);
        rst = 1'b0;
        m_hi = '0;
        m_lo = '0;
    endtask

    task automatic test_overflow;
        logic [5:0] ops [0:2] = '{OP_ADD, OP_ADDU, OP_SUB};
        logic [31:0] as [0:2] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000};
        logic [31:0] ys [0:2] = '{32'h80000000, 32'h80000000, 32'h7FFFFFFF};
        logic ovs [0:2] = '{1'b1, 1'b0, 1'b1};
        int lat, nb;
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], as[i], 32'h1, 5'd0, lat, nb);
            n_tests++;
            if ({bus.o_y, bus.o_overflow} !== {ys[i], ovs[i]} || lat !== 1) begin
                $display("FAIL overflow[%0d]: y=%h ov=%b lat=%0d, want y=%h ov=%b lat=1",
                         i, bus.o_y, bus.o_overflow, lat, ys[i], ovs[i]);
                n_fail++;
            end
        end
    endtask

    task automatic test_single_random;
        logic [5:0] ops [0:24] = '{OP_XOR, OP_NOR, OP_AND, OP_OR, OP_LUI, OP_SLL, OP_SRL, OP_SRA,
            OP_SLLV, OP_SRLV, OP_SRAV, OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_SLT, OP_SLTU,
            OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO, 6'b000000, 6'b111111, 6'b011111, 6'b100111};
        logic [31:0] a, b, ey;
        logic [5:0] op;
        logic [4:0] s;
        logic eov;
        int lat, nb, elat;
        for (int i = 0; i < 80; i++) begin
            op = ops[$urandom_range(0, 24)];
            a = ($urandom_range(0, 3) == 0) ? {$urandom_range(0, 1) == 1, 31'h7FFFFFFF} : $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            s = 5'($urandom);
            model(op, a, b, s, ey, eov, elat);
            issue(op, a, b, s, lat, nb);
            n_tests++;
            if ({bus.o_y, bus.o_overflow, bus.o_hi, bus.o_lo} !== {ey, eov, m_hi, m_lo} || lat !== elat) begin
                $display("FAIL single op=%b a=%h b=%h sa=%0d: y=%h ov=%b hi=%h lo=%h lat=%0d, want y=%h ov=%b hi=%h lo=%h lat=%0d",
                         op, a, b, s, bus.o_y, bus.o_overflow, bus.o_hi, bus.o_lo, lat, ey, eov, m_hi, m_lo, elat);
                n_fail++;
            end
        end
    endtask

    task automatic test_mult;
        logic [31:0] ey;
        logic eov;
        int lat, nb, elat;
        model(OP_MULT, 32'hFFFFFFFE, 32'h3, 5'd0, ey, eov, elat);
        issue(OP_MULT, 32'hFFFFFFFE, 32'h3, 5'd0, lat, nb);
        n_tests++;
        if ({bus.o_hi, bus.o_lo, bus.o_y} !== {32'hFFFFFFFF, 32'hFFFFFFFA, 32'hFFFFFFFA} || lat !== 33 || nb !== 32) begin
            $display("FAIL mult: hi=%h lo=%h y=%h lat=%0d busy=%0d, want hi=ffffffff lo=fffffffa y=fffffffa lat=33 busy=32",
                     bus.o_hi, bus.o_lo, bus.o_y, lat, nb);
            n_fail++;
        end
        model(OP_MULTU, 32'hFFFFFFFE, 32'h3, 5'd0, ey, eov, elat);
        issue(OP_MULTU, 32'hFFFFFFFE, 32'h3, 5'd0, lat, nb);
        n_tests++;
        if ({bus.o_hi, bus.o_lo} !== {32'h2, 32'hFFFFFFFA} || lat !== 33 || bus.o_overflow !== 1'b0) begin
            $display("FAIL multu: hi=%h lo=%h lat=%0d ov=%b, want hi=00000002 lo=fffffffa lat=33 ov=0",
                     bus.o_hi, bus.o_lo, lat, bus.o_overflow);
            n_fail++;
        end
    endtask

    task automatic test_div;
        logic [31:0] ey;
        logic eov;
        int lat, nb, elat;
`ifdef ALU_MC_DIV_EN
        logic [5:0] ops [0:2] = '{OP_DIV, OP_DIVU, OP_DIV};
        logic [31:0] as [0:2] = '{32'hFFFFFFF9, 32'h9, 32'h80000000};
        logic [31:0] bs [0:2] = '{32'h2, 32'h0, 32'hFFFFFFFF};
        logic [31:0] his [0:2] = '{32'hFFFFFFFF, 32'h9, 32'h0};
        logic [31:0] los [0:2] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000};
        for (int i = 0; i < 3; i++) begin
            model(ops[i], as[i], bs[i], 5'd0, ey, eov, elat);
            issue(ops[i], as[i], bs[i], 5'd0, lat, nb);
            n_tests++;
            if ({bus.o_hi, bus.o_lo, bus.o_overflow} !== {his[i], los[i], 1'b0} || lat !== 33) begin
                $display("FAIL div[%0d]: hi=%h lo=%h ov=%b lat=%0d, want hi=%h lo=%h ov=0 lat=33",
                         i, bus.o_hi, bus.o_lo, bus.o_overflow, lat, his[i], los[i]);
                n_fail++;
            end
        end
`else
        model(OP_MTHI, 32'h12345678, 32'h0, 5'd0, ey, eov, elat);
        issue(OP_MTHI, 32'h12345678, 32'h0, 5'd0, lat, nb);
        model(OP_MTLO, 32'h9ABCDEF0, 32'h0, 5'd0, ey, eov, elat);
        issue(OP_MTLO, 32'h9ABCDEF0, 32'h0, 5'd0, lat, nb);
        issue(OP_DIV, 32'h8, 32'h2, 5'd0, lat, nb);
        n_tests++;
        if ({bus.o_y, bus.o_hi, bus.o_lo} !== {32'h0, 32'h12345678, 32'h9ABCDEF0} || lat !== 1 || nb !== 0) begin
            $display("FAIL div_absent: y=%h hi=%h lo=%h lat=%0d busy=%0d, want y=0 hi=12345678 lo=9abcdef0 lat=1 busy=0",
                     bus.o_y, bus.o_hi, bus.o_lo, lat, nb);
            n_fail++;
        end
`endif
    endtask

    task automatic test_iter_random;
        logic [5:0] ops [0:3] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
        logic [31:0] a, b, ey;
        logic [5:0] op;
        logic eov;
        int lat, nb, elat;
        for (int i = 0; i < 16; i++) begin
            op = ops[$urandom_range(0, 3)];
            a = $urandom;
            b = ($urandom_range(0, 4) == 0) ? 32'h0 : ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 300));
            model(op, a, b, 5'd0, ey, eov, elat);
            issue(op, a, b, 5'd0, lat, nb);
            n_tests++;
            if ({bus.o_y, bus.o_overflow, bus.o_hi, bus.o_lo} !== {ey, eov, m_hi, m_lo} || lat !== elat) begin
                $display("FAIL iter op=%b a=%h b=%h: y=%h ov=%b hi=%h lo=%h lat=%0d, want y=%h ov=%b hi=%h lo=%h lat=%0d",
                         op, a, b, bus.o_y, bus.o_overflow, bus.o_hi, bus.o_lo, lat, ey, eov, m_hi, m_lo, elat);
                n_fail++;
            end
        end
    endtask

    task automatic test_busy_ignore;
        logic [31:0] a, b, ey;
        logic eov;
        int lat, nb, elat;
        a = $urandom;
        b = $urandom;
        model(OP_MULT, a, b, 5'd0, ey, eov, elat);
        @(negedge clk);
        bus.i_op = OP_MULT;
        bus.i_a = a;
        bus.i_b = b;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        lat = 1;
        while (!bus.o_done && lat < 100) begin
            bus.i_start = lat == 5;
            bus.i_op = OP_MTLO;
            bus.i_a = $urandom;
            @(posedge clk);
            #1;
            lat++;
        end
        bus.i_start = 1'b0;
        n_tests++;
        if ({bus.o_hi, bus.o_lo} !== {m_hi, m_lo} || lat !== 33) begin
            $display("FAIL busy_ignore: hi=%h lo=%h lat=%0d, want hi=%h lo=%h lat=33", bus.o_hi, bus.o_lo, lat, m_hi, m_lo);
            n_fail++;
        end
        model(OP_MFHI, 32'h0, 32'h0, 5'd0, ey, eov, elat);
        issue(OP_MFHI, 32'h0, 32'h0, 5'd0, lat, nb);
        n_tests++;
        if (bus.o_y !== ey || lat !== 1) begin
            $display("FAIL mfhi_after_mult: y=%h lat=%0d, want y=%h lat=1", bus.o_y, lat, ey);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid;
        int bad, lat, nb;
`ifdef ALU_MC_DIV_EN
        logic [5:0] op = OP_DIV;
`else
        logic [5:0] op = OP_MULT;
`endif
        @(negedge clk);
        bus.i_op = op;
        bus.i_a = 32'hDEADBEEF;
        bus.i_b = 32'h7;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({bus.o_y, bus.o_hi, bus.o_lo, bus.o_busy, bus.o_done, bus.o_overflow} !== '0) begin
            $display("FAIL reset_mid: y=%h hi=%h lo=%h busy=%b done=%b ov=%b, want all 0",
                     bus.o_y, bus.o_hi, bus.o_lo, bus.o_busy, bus.o_done, bus.o_overflow);
            n_fail++;
        end
        @(negedge clk);
        rst = 1'b0;
        m_hi = '0;
        m_lo = '0;
        bad = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.o_done || bus.o_busy) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            $display("FAIL reset_mid_quiet: %0d cycles with done/busy after reset, want 0", bad);
            n_fail++;
        end
        issue(OP_SLL, 32'h0, 32'h1, 5'd4, lat, nb);
        n_tests++;
        if ({bus.o_y, bus.o_hi, bus.o_lo} !== {32'h10, 32'h0, 32'h0} || lat !== 1) begin
            $display("FAIL sll_after_reset: y=%h hi=%h lo=%h lat=%0d, want y=10 hi=0 lo=0 lat=1",
                     bus.o_y, bus.o_hi, bus.o_lo, lat);
            n_fail++;
        end
    endtask

    initial begin
        bus.i_start = 1'b0;
        bus.i_op = '0;
        bus.i_a = '0;
        bus.i_b = '0;
        bus.i_sa = '0;
        test_reset;
        test_overflow;
        test_single_random;
        test_mult;
        test_div;
        test_iter_random;
        test_busy_ignore;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
